// File: rtl/delqa_pkg.sv
// rtl/delqa_pkg.sv - shared constants and types for the DMA scheduler
// Purpose: channel indices, transfer direction encoding and scheduler FSM states.
// Ports: none (package).
package delqa_pkg;

  localparam int         NCH       = 3;
  localparam logic [1:0] CH_BDL    = 2'd0;
  localparam logic [1:0] CH_RX     = 2'd1;
  localparam logic [1:0] CH_TX     = 2'd2;
  localparam logic       DIR_TOMEM = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PICK,
    ST_CMD,
    ST_RUN,
    ST_POST
  } state_t;

endpackage

// File: rtl/dma_rr_pick.sv
// rtl/dma_rr_pick.sv - channel winner select: fixed BDL priority, RX/TX round robin
// Purpose: chooses which active channel gets the next engine burst.
// Ports:
//   i_act  in  3  channels eligible for a burst ([0]=BDL [1]=RX [2]=TX)
//   i_ptr  in  2  preferred channel when RX and TX are both eligible
//   o_win  out 2  winning channel index
//   o_vld  out 1  at least one channel eligible
module dma_rr_pick
  import delqa_pkg::*;
(
  input  logic [NCH-1:0] i_act,
  input  logic [1:0]     i_ptr,
  output logic [1:0]     o_win,
  output logic           o_vld
);

  always_comb begin
    o_vld = |i_act;
    o_win = CH_BDL;
    if (i_act[CH_BDL]) begin
      o_win = CH_BDL;
    end else if (i_act[CH_RX] && i_act[CH_TX]) begin
      o_win = i_ptr;
    end else if (i_act[CH_RX]) begin
      o_win = CH_RX;
    end else if (i_act[CH_TX]) begin
      o_win = CH_TX;
    end
  end

endmodule

// File: rtl/dma_sched.sv
// rtl/dma_sched.sv - burst scheduler sharing one DMA engine between BDL, RX and TX
// Purpose: holds a context per channel, splits transfers into bursts of at most
//   BURST words and re-arbitrates after every burst so RX is never starved by TX.
// Ports:
//   clk_i, rst_i                  clock, async active-high reset
//   req_i/badr_i/ladr_i/len_i/dir_i  per-channel request level and transfer context
//   acc_o/done_o/err_o            per-channel 1-cycle accept/complete/abort pulses
//   eng_start_o..eng_dir_o        engine command (strobe, addresses, length, direction)
//   eng_done_i/eng_err_i          engine completion pulse and its error qualifier
//   rxmode_o/txmode_o             RX/TX channel currently owns the engine
//   busy_o                        any channel active
module dma_sched
  import delqa_pkg::*;
#(
  parameter int BURST = 16,
  parameter int LENW  = 12
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [2:0]          req_i,
  input  logic [62:0]         badr_i,
  input  logic [44:0]         ladr_i,
  input  logic [3*LENW-1:0]   len_i,
  input  logic [2:0]          dir_i,
  output logic [2:0]          acc_o,
  output logic [2:0]          done_o,
  output logic [2:0]          err_o,
  output logic                eng_start_o,
  output logic [20:0]         eng_badr_o,
  output logic [14:0]         eng_ladr_o,
  output logic [8:0]          eng_len_o,
  output logic                eng_dir_o,
  input  logic                eng_done_i,
  input  logic                eng_err_i,
  output logic                rxmode_o,
  output logic                txmode_o,
  output logic                busy_o
);

  localparam logic [LENW-1:0] BURST_W = LENW'(BURST);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [20:0]     r_badr [NCH];
  logic [14:0]     r_ladr [NCH];
  logic [LENW-1:0] r_rem  [NCH];
  logic [NCH-1:0]  r_dir;
  logic [NCH-1:0]  r_act;
  logic [NCH-1:0]  r_nul;     // accepted with len=0: completes next cycle, never scheduled
  logic [NCH-1:0]  r_acc;
  logic [NCH-1:0]  r_done;
  logic [NCH-1:0]  r_err;
  logic [1:0]      r_own;
  logic [1:0]      r_ptr;
  logic            r_eerr;    // error qualifier captured with eng_done_i, consumed in POST

  logic [NCH-1:0]  w_acc_en;
  logic [NCH-1:0]  w_sched;
  logic [NCH-1:0]  w_own_oh;
  logic [NCH-1:0]  w_fin_oh;
  logic [1:0]      w_win;
  logic            w_vld;
  logic [LENW-1:0] w_rem_own;
  logic [LENW-1:0] w_seg;
  logic            w_last;
  logic            w_post;
  logic            w_eng;

  assign w_acc_en  = req_i & ~r_act;
  assign w_sched   = r_act & ~r_nul;
  assign w_own_oh  = 3'b001 << r_own;
  assign w_rem_own = r_rem[r_own];
  assign w_seg     = (w_rem_own < BURST_W) ? w_rem_own : BURST_W;
  assign w_last    = (w_rem_own == w_seg);
  assign w_post    = (r_state == ST_POST);
  assign w_fin_oh  = (w_post && (r_eerr || w_last)) ? w_own_oh : '0;
  assign w_eng     = (r_state == ST_CMD) || (r_state == ST_RUN) || (r_state == ST_POST);

  dma_rr_pick u_pick (
    .i_act (w_sched),
    .i_ptr (r_ptr),
    .o_win (w_win),
    .o_vld (w_vld)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    eng_start_o = 1'b0;
    unique case (r_state)
      ST_IDLE: if (|w_sched) w_state_nxt = ST_PICK;
      ST_PICK: w_state_nxt = w_vld ? ST_CMD : ST_IDLE;
      ST_CMD: begin
        eng_start_o = 1'b1;
        w_state_nxt = ST_RUN;
      end
      ST_RUN:  if (eng_done_i) w_state_nxt = ST_POST;
      // a channel finishing in this POST must not keep the FSM out of IDLE
      ST_POST: w_state_nxt = (|(w_sched & ~w_fin_oh)) ? ST_PICK : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NCH; k++) begin
        r_badr[k] <= '0;
        r_ladr[k] <= '0;
        r_rem[k]  <= '0;
      end
      r_dir  <= '0;
      r_act  <= '0;
      r_nul  <= '0;
      r_acc  <= '0;
      r_done <= '0;
      r_err  <= '0;
      r_own  <= CH_BDL;
      r_ptr  <= CH_RX;
      r_eerr <= 1'b0;
    end else begin
      r_acc <= w_acc_en;
      for (int k = 0; k < NCH; k++) begin
        r_done[k] <= r_nul[k] | (w_post & ~r_eerr & w_last & w_own_oh[k]);
        r_err[k]  <= w_post & r_eerr & w_own_oh[k];
        if (r_nul[k]) begin
          r_act[k] <= 1'b0;
          r_nul[k] <= 1'b0;
        end else if (w_acc_en[k]) begin
          r_badr[k] <= badr_i[k*21 +: 21];
          r_ladr[k] <= ladr_i[k*15 +: 15];
          r_rem[k]  <= len_i[k*LENW +: LENW];
          r_dir[k]  <= dir_i[k];
          r_act[k]  <= 1'b1;
          r_nul[k]  <= (len_i[k*LENW +: LENW] == '0);
        end else if (w_post && w_own_oh[k]) begin
          if (r_eerr) begin
            r_rem[k] <= '0;
            r_act[k] <= 1'b0;
          end else begin
            r_badr[k] <= r_badr[k] + 21'(w_seg);
            r_ladr[k] <= r_ladr[k] + 15'(w_seg);
            r_rem[k]  <= r_rem[k] - w_seg;
            if (w_last) r_act[k] <= 1'b0;
          end
        end
      end
      if (r_state == ST_PICK) r_own <= w_win;
      if (r_state == ST_RUN && eng_done_i) r_eerr <= eng_err_i;
      // round robin moves on only once a burst has actually finished
      if (w_post) begin
        if (r_own == CH_RX) r_ptr <= CH_TX;
        else if (r_own == CH_TX) r_ptr <= CH_RX;
      end
    end
  end

  assign acc_o      = r_acc;
  assign done_o     = r_done;
  assign err_o      = r_err;
  assign busy_o     = |r_act;
  assign eng_badr_o = w_eng ? r_badr[r_own] : '0;
  assign eng_ladr_o = w_eng ? r_ladr[r_own] : '0;
  assign eng_len_o  = w_eng ? 9'(w_seg) : '0;
  assign eng_dir_o  = w_eng & (r_dir[r_own] == DIR_TOMEM);
  assign rxmode_o   = w_eng & (r_own == CH_RX);
  assign txmode_o   = w_eng & (r_own == CH_TX);

endmodule

// File: tb/tb_dma_sched.sv
// tb/tb_dma_sched.sv - self-checking bench for dma_sched
module tb_dma_sched;
  import delqa_pkg::*;

  localparam int LENW  = 12;
  localparam int BURST = 16;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [2:0]        req_i;
  logic [62:0]       badr_i;
  logic [44:0]       ladr_i;
  logic [3*LENW-1:0] len_i;
  logic [2:0]        dir_i;
  logic [2:0]        acc_o, done_o, err_o;
  logic              eng_start_o, eng_dir_o, rxmode_o, txmode_o, busy_o;
  logic [20:0]       eng_badr_o;
  logic [14:0]       eng_ladr_o;
  logic [8:0]        eng_len_o;
  logic              eng_done_i = 1'b0;
  logic              eng_err_i  = 1'b0;

  always #5 clk_i = ~clk_i;

  logic [2:0]  d_req = '0;
  logic [20:0] d_badr [3];
  logic [14:0] d_ladr [3];
  int          d_len  [3];
  logic [2:0]  d_dir = '0;

  assign req_i  = d_req;
  assign badr_i = {d_badr[2], d_badr[1], d_badr[0]};
  assign ladr_i = {d_ladr[2], d_ladr[1], d_ladr[0]};
  assign len_i  = {LENW'(d_len[2]), LENW'(d_len[1]), LENW'(d_len[0])};
  assign dir_i  = d_dir;

  dma_sched #(.BURST(BURST), .LENW(LENW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .badr_i(badr_i), .ladr_i(ladr_i),
    .len_i(len_i), .dir_i(dir_i), .acc_o(acc_o), .done_o(done_o), .err_o(err_o),
    .eng_start_o(eng_start_o), .eng_badr_o(eng_badr_o), .eng_ladr_o(eng_ladr_o),
    .eng_len_o(eng_len_o), .eng_dir_o(eng_dir_o), .eng_done_i(eng_done_i),
    .eng_err_i(eng_err_i), .rxmode_o(rxmode_o), .txmode_o(txmode_o), .busy_o(busy_o)
  );

  // transaction-level reference: remaining words and offset per channel
  int          n_cmp = 0, n_bad = 0, cyc = 0;
  logic [2:0]  m_act;
  int          m_rem [3];
  int          m_off [3];
  logic [20:0] m_badr [3];
  logic [14:0] m_ladr [3];
  logic [2:0]  m_dir;
  logic [2:0]  pd_now, pd_nxt, pe_now, pe_nxt;
  int          last_rt, own_win, eng_cnt, cur_ch, cur_idx, eng_dly, err_at;
  bit          inflight, post_pend, rand_mode, sole;
  int          n_start, first_start, last_start, last_len, req_cyc;
  int          n_done_obs [3];
  int          n_err_obs  [3];
  int          own_q [$];

  typedef struct {
    int ch;
    int len;
    int starts;
    int last_len;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  function automatic int min_seg(input int r);
    return (r < BURST) ? r : BURST;
  endfunction

  task automatic model_clear();
    m_act = '0; pd_now = '0; pd_nxt = '0; pe_now = '0; pe_nxt = '0;
    for (int k = 0; k < 3; k++) begin m_rem[k] = 0; m_off[k] = 0; end
    inflight = 0; post_pend = 0; own_win = -1; last_rt = 2; err_at = -1;
  endtask

  task automatic clear_stats();
    n_start = 0; own_q.delete();
    for (int k = 0; k < 3; k++) begin n_done_obs[k] = 0; n_err_obs[k] = 0; end
  endtask

  task automatic tick();
    logic [2:0]  prev_act, exp_acc, elig;
    logic [20:0] eb;
    logic [14:0] el;
    int          w;
    bit          started, e;
    @(negedge clk_i);
    cyc++;
    prev_act = m_act;
    exp_acc  = d_req & ~m_act;
    m_act    = (m_act & ~(pd_now | pe_now)) | exp_acc;
    chk("acc_o", acc_o, exp_acc);
    chk("done_o", done_o, pd_now);
    chk("err_o", err_o, pe_now);
    chk("busy_o", busy_o, |m_act);
    for (int k = 0; k < 3; k++) begin
      n_done_obs[k] += int'(done_o[k]);
      n_err_obs[k]  += int'(err_o[k]);
    end
    pd_now = pd_nxt; pd_nxt = '0; pe_now = pe_nxt; pe_nxt = '0;
    for (int k = 0; k < 3; k++) begin
      if (exp_acc[k]) begin
        m_rem[k] = d_len[k]; m_off[k] = 0;
        m_badr[k] = d_badr[k]; m_ladr[k] = d_ladr[k]; m_dir[k] = d_dir[k];
        if (d_len[k] == 0) pd_now[k] = 1'b1;
        d_len[k]  = (k == 0) ? $urandom_range(0, 8) : $urandom_range(0, 40);
        d_badr[k] = 21'($urandom);
        d_ladr[k] = 15'($urandom);
        d_dir[k]  = 1'($urandom);
      end
    end
    started = 0;
    if (eng_start_o) begin
      chk("start_while_busy", inflight, 0);
      for (int k = 0; k < 3; k++) elig[k] = prev_act[k] && (m_rem[k] > 0);
      if (elig[0]) w = 0;
      else if (elig[1] && elig[2]) w = (last_rt == 1) ? 2 : 1;
      else if (elig[1]) w = 1;
      else if (elig[2]) w = 2;
      else w = -1;
      chk("start_owner", rxmode_o ? 1 : (txmode_o ? 2 : 0), w);
      if (w >= 0) begin
        eb = m_badr[w] + 21'(m_off[w]);
        el = m_ladr[w] + 15'(m_off[w]);
        chk("eng_len", eng_len_o, min_seg(m_rem[w]));
        chk("eng_badr", eng_badr_o, eb);
        chk("eng_ladr", eng_ladr_o, el);
        chk("eng_dir", eng_dir_o, m_dir[w]);
      end
      n_start++;
      own_q.push_back(w);
      if (n_start == 1) first_start = cyc;
      else if (sole) chk("burst_gap", cyc - last_start, 4 + eng_dly);
      last_start = cyc; last_len = int'(eng_len_o);
      cur_ch = w; cur_idx = n_start; inflight = 1; started = 1; own_win = w;
      eng_cnt = rand_mode ? $urandom_range(0, 3) : eng_dly;
    end
    chk("rxmode", rxmode_o, own_win == 1);
    chk("txmode", txmode_o, own_win == 2);
    if (post_pend) begin own_win = -1; post_pend = 0; end
    eng_done_i = 1'b0; eng_err_i = 1'b0;
    if (inflight && !started) begin
      if (eng_cnt == 0) begin
        e = (cur_idx == err_at) || (rand_mode && $urandom_range(0, 15) == 0);
        eng_done_i = 1'b1; eng_err_i = e; inflight = 0; post_pend = 1;
        if (cur_ch >= 0) begin
          if (e) begin
            m_rem[cur_ch] = 0; pe_nxt[cur_ch] = 1'b1;
          end else begin
            m_off[cur_ch] += min_seg(m_rem[cur_ch]);
            m_rem[cur_ch] -= min_seg(m_rem[cur_ch]);
            if (m_rem[cur_ch] == 0) pd_nxt[cur_ch] = 1'b1;
          end
          if (cur_ch != 0) last_rt = cur_ch;
        end
      end else begin
        eng_cnt--;
      end
    end
  endtask

  task automatic do_reset();
    d_req = '0; eng_done_i = 1'b0; eng_err_i = 1'b0; rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_pulses", {acc_o, done_o, err_o, eng_start_o, rxmode_o, txmode_o, busy_o}, 0);
    chk("rst_eng", {eng_badr_o, eng_ladr_o, eng_len_o, eng_dir_o}, 0);
    model_clear();
    rst_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 3000; i++) begin
      if (m_act == 0 && !inflight && !post_pend && pd_now == 0 && pe_now == 0) break;
      tick();
    end
    chk(name, i < 3000, 1);
  endtask

  task automatic wait_start(input int n);
    int i;
    for (i = 0; i < 100; i++) begin
      if (n_start >= n) break;
      tick();
    end
    chk("wait_start", i < 100, 1);
  endtask

  int exp_a [4] = '{1, 2, 1, 2};
  int exp_b [4] = '{2, 0, 2, 2};

  initial begin
    for (int k = 0; k < 3; k++) begin d_badr[k] = '0; d_ladr[k] = '0; d_len[k] = 0; end
    vecs[0] = '{0, 6, 1, 6};
    vecs[1] = '{2, 40, 3, 8};
    vecs[2] = '{1, 16, 1, 16};
    vecs[3] = '{1, 17, 2, 1};
    vecs[4] = '{2, 1, 1, 1};
    vecs[5] = '{0, 33, 3, 1};
    vecs[6] = '{2, 0, 0, 0};
    rand_mode = 0; sole = 0; eng_dly = 0;
    model_clear();
    clear_stats();
    do_reset();

    for (int i = 0; i < 7; i++) begin
      clear_stats();
      eng_dly = i % 3;
      sole = 1;
      d_len[vecs[i].ch]  = vecs[i].len;
      d_badr[vecs[i].ch] = 21'h1FFFF8 + 21'(i);
      d_ladr[vecs[i].ch] = 15'h7FF0;
      d_dir[vecs[i].ch]  = 1'(i);
      d_req[vecs[i].ch]  = 1'b1;
      req_cyc = cyc;
      tick();
      d_req = '0;
      wait_idle("vec_idle");
      sole = 0;
      chk("vec_starts", n_start, vecs[i].starts);
      if (vecs[i].starts > 0) begin
        chk("vec_last_len", last_len, vecs[i].last_len);
        chk("vec_latency", first_start - req_cyc, 3);
      end
      chk("vec_done_cnt", n_done_obs[vecs[i].ch], 1);
      chk("vec_err_cnt", n_err_obs[vecs[i].ch], 0);
    end

    clear_stats();
    eng_dly = 1;
    d_len[1] = 32; d_len[2] = 32; d_req = 3'b110;
    tick();
    d_req = '0;
    wait_idle("rrx_idle");
    chk("rrx_nbursts", own_q.size(), 4);
    for (int i = 0; i < 4 && i < own_q.size(); i++) chk("rrx_order", own_q[i], exp_a[i]);

    clear_stats();
    eng_dly = 3;
    d_len[2] = 48; d_req = 3'b100;
    tick();
    d_req = '0;
    wait_start(1);
    d_len[0] = 5; d_req = 3'b001;
    tick();
    d_req = '0;
    wait_idle("bdl_idle");
    chk("bdl_nbursts", own_q.size(), 4);
    for (int i = 0; i < 4 && i < own_q.size(); i++) chk("bdl_order", own_q[i], exp_b[i]);

    clear_stats();
    eng_dly = 2; err_at = 2;
    d_len[1] = 40; d_req = 3'b010;
    tick();
    d_req = '0;
    wait_idle("err_idle");
    chk("err_starts", n_start, 2);
    chk("err_pulses", n_err_obs[1], 1);
    chk("err_no_done", n_done_obs[1], 0);
    err_at = -1;

    clear_stats();
    eng_dly = 6;
    d_len[0] = 40; d_req = 3'b001;
    tick();
    d_req = '0;
    wait_start(1);
    tick();
    tick();
    chk("pre_rst_busy", busy_o, 1);
    #2 rst_i = 1'b1;
    #1 chk("rst_async", {busy_o, eng_start_o, rxmode_o, txmode_o, eng_len_o, eng_badr_o}, 0);
    do_reset();

    clear_stats();
    rand_mode = 1; eng_dly = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 3; k++) d_req[k] = ($urandom_range(0, 2) == 0);
      tick();
    end
    d_req = '0;
    wait_idle("rand_idle");
    rand_mode = 0;
    tick();
    chk("final_busy", busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
